// File: rtl/fp_norm_pack_pkg.sv
// Shared definitions for the single-precision adder normalise-and-pack stage.
package fp_norm_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } norm_state_e;

    localparam int unsigned EXP_BIAS = 127;
    localparam logic [7:0] EXP_INF = 8'hFF;
    localparam logic [7:0] EXP_MAX_NORMAL = 8'hFE;

    // Packed result field offsets
    localparam int unsigned RES_SIGN_BIT = 31;
    localparam int unsigned RES_EXP_MSB = 30;
    localparam int unsigned RES_EXP_LSB = 23;
    localparam int unsigned RES_FRAC_MSB = 22;
    localparam int unsigned RES_FRAC_LSB = 0;

endpackage

// File: rtl/fp_norm_pack.sv
// Iterative normaliser: shifts the ALU magnitude one bit per cycle, then packs an IEEE-754 word.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | one normalise step per cycle until packed
// DONE  | result held with out_valid until out_ready
module fp_norm_pack
    import fp_norm_pack_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int EXP_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH:0]                mant_in,
    input  logic                               sign_in,
    input  logic [EXP_WIDTH-1:0]               exp_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [EXP_WIDTH+DATA_WIDTH-1:0]    result,
    output logic                               zero,
    output logic                               overflow
);

    localparam int RES_W = EXP_WIDTH + DATA_WIDTH;

    norm_state_e              state, state_nx;
    logic [DATA_WIDTH:0]      mant_r, mant_nx;
    logic [EXP_WIDTH-1:0]     exp_r, exp_nx;
    logic                     sign_r, sign_nx;
    logic [RES_W-1:0]         result_nx;
    logic                     zero_nx, overflow_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mant_r   <= '0;
            exp_r    <= '0;
            sign_r   <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            mant_r   <= mant_nx;
            exp_r    <= exp_nx;
            sign_r   <= sign_nx;
            result   <= result_nx;
            zero     <= zero_nx;
            overflow <= overflow_nx;
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    always_comb begin
        state_nx    = state;
        mant_nx     = mant_r;
        exp_nx      = exp_r;
        sign_nx     = sign_r;
        result_nx   = result;
        zero_nx     = zero;
        overflow_nx = overflow;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    mant_nx  = mant_in;
                    sign_nx  = sign_in;
                    // A zero exponent carries the same scale as exponent 1 (denormal range)
                    exp_nx   = (exp_in == '0) ? EXP_WIDTH'(1) : exp_in;
                    state_nx = ST_NORM;
                end
            end
            ST_NORM: begin
                if (mant_r == '0) begin
                    result_nx   = '0;
                    zero_nx     = 1'b1;
                    overflow_nx = 1'b0;
                    state_nx    = ST_DONE;
                end else if (mant_r[DATA_WIDTH]) begin
                    zero_nx  = 1'b0;
                    state_nx = ST_DONE;
                    if (exp_r == EXP_WIDTH'(EXP_MAX_NORMAL)) begin
                        result_nx   = {sign_r, EXP_WIDTH'(EXP_INF), {(DATA_WIDTH-1){1'b0}}};
                        overflow_nx = 1'b1;
                    end else begin
                        mant_nx     = mant_r >> 1;
                        exp_nx      = exp_r + EXP_WIDTH'(1);
                        result_nx   = {sign_r, exp_nx, mant_r[DATA_WIDTH-1:1]};
                        overflow_nx = 1'b0;
                    end
                end else if (mant_r[DATA_WIDTH-1]) begin
                    result_nx   = {sign_r, exp_r, mant_r[DATA_WIDTH-2:0]};
                    zero_nx     = 1'b0;
                    overflow_nx = 1'b0;
                    state_nx    = ST_DONE;
                end else if (exp_r == EXP_WIDTH'(1)) begin
                    result_nx   = {sign_r, {EXP_WIDTH{1'b0}}, mant_r[DATA_WIDTH-2:0]};
                    zero_nx     = 1'b0;
                    overflow_nx = 1'b0;
                    state_nx    = ST_DONE;
                end else begin
                    mant_nx = mant_r << 1;
                    exp_nx  = exp_r - EXP_WIDTH'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed bench for fp_norm_pack: hand-computed IEEE-754 results, latency, backpressure, reset abort.
module tb_fp_norm_pack;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] mant_in;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    fp_norm_pack #(.DATA_WIDTH(24), .EXP_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_in   (mant_in),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Accepts one operand; returns number of edges from accept to out_valid (0 on timeout).
    task automatic send_and_wait(input logic [24:0] m, input logic [7:0] e, input logic s,
                                 output int lat);
        @(negedge clk);
        mant_in  = m;
        exp_in   = e;
        sign_in  = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_txn(input string tag, input logic [24:0] m, input logic [7:0] e,
                           input logic s, input logic [31:0] want_res, input logic want_zero,
                           input logic want_ovf, input int want_lat);
        int lat;
        send_and_wait(m, e, s, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(want_lat));
        chk({tag, "_res"}, result, want_res);
        chk({tag, "_zero"}, 32'(zero), 32'(want_zero));
        chk({tag, "_ovf"}, 32'(overflow), 32'(want_ovf));
        chk({tag, "_inrdy"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'b10);
        chk({tag, "_hold"}, result, want_res);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mant_in   = '0;
        exp_in    = '0;
        sign_in   = 1'b0;
        #1;
        chk("rst_inrdy", 32'(in_ready), 32'd1);
        chk("rst_oval", 32'(out_valid), 32'd0);
        chk("rst_res", result, 32'h0);
        chk("rst_flags", {30'd0, zero, overflow}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_txn("carry",   25'h100_0000, 8'd127, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 1);
        run_txn("shift1",  25'h040_0000, 8'd127, 1'b1, 32'hBF00_0000, 1'b0, 1'b0, 2);
        run_txn("zero",    25'h000_0000, 8'd100, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1);
        run_txn("ovf",     25'h100_0000, 8'd254, 1'b1, 32'hFF80_0000, 1'b0, 1'b1, 1);
        run_txn("denorm",  25'h000_0001, 8'd3,   1'b0, 32'h0000_0004, 1'b0, 1'b0, 3);
        run_txn("exp0",    25'h080_0000, 8'd0,   1'b0, 32'h0080_0000, 1'b0, 1'b0, 1);
        run_txn("carry_e0",25'h100_0001, 8'd0,   1'b1, 32'h8100_0000, 1'b0, 1'b0, 1);
        run_txn("sh20",    25'h000_0008, 8'd127, 1'b0, 32'h3580_0000, 1'b0, 1'b0, 21);

        // backpressure: result and handshake state stay put while out_ready is low
        send_and_wait(25'h040_0000, 8'd127, 1'b1, lat);
        chk("bp_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_res", result, 32'hBF00_0000);
            chk("bp_hs", {30'd0, in_ready, out_valid}, 32'b01);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);

        // reset in the middle of a long normalisation
        @(negedge clk);
        mant_in  = 25'h000_0008;
        exp_in   = 8'd127;
        sign_in  = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_norm_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_inrdy", 32'(in_ready), 32'd1);
        chk("abort_oval", 32'(out_valid), 32'd0);
        chk("abort_res", result, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat++;
        end
        chk("abort_no_oval", 32'(lat), 32'd0);

        run_txn("post_rst", 25'h000_0008, 8'd127, 1'b0, 32'h3580_0000, 1'b0, 1'b0, 21);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_norm_pack.md
# fp_norm_pack

Sequential normalise-and-pack stage directly downstream of the 24-bit mantissa add/subtract ALU in the single-precision IEEE-754 adder. It takes the ALU's 25-bit unsigned magnitude, result sign and the common (larger) biased exponent from the alignment stage. It normalises the mantissa iteratively, one bit per cycle, and emits a packed 32-bit IEEE-754 word with zero/overflow flags over a valid/ready handshake.

## Interface
- DATA_WIDTH, 24: mantissa width including hidden bit; ALU magnitude is DATA_WIDTH+1 bits.
- EXP_WIDTH, 8: biased exponent width.
- clk  in  1  rising-edge clock; one clock; all state on clk.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream operand valid.
- in_ready  out  1  block can accept; high only in IDLE.
- mant_in  in  25  ALU magnitude (bit 24 = carry out of add).
- sign_in  in  1  ALU result sign.
- exp_in  in  8  common biased exponent, legal range 0..254; 0 is treated as scale 1 (denormal scale).
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  downstream accepts.
- result  out  32  {sign, exponent field, fraction[22:0]}.
- zero  out  1  result is +0.
- overflow  out  1  result is signed infinity.

## Operation
- FSM states: IDLE, NORM, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, load mant_r<=mant_in, sign_r<=sign_in, exp_r<=(exp_in==0 ? 1 : exp_in). Go to NORM.
- NORM evaluates once per cycle, in priority order:
  - mant_r==0: result=32'h0000_0000 (sign forced 0), zero=1. Go to DONE.
  - mant_r[24]=1: if exp_r==254, result={sign_r,8'hFF,23'h0}, overflow=1. Else mant_r>>1 (LSB truncated, round toward zero), exp_r+1, pack. Go to DONE.
  - mant_r[23]=1: pack {sign_r, exp_r, mant_r[22:0]}. Go to DONE.
  - exp_r==1 with mant_r[23]=0: denormal; pack {sign_r, 8'h00, mant_r[22:0]}. Go to DONE.
  - Else: mant_r<<1, exp_r-1. Stay in NORM.
- DONE: out_valid=1; result, zero and overflow stable. On out_ready go to IDLE; output registers hold their last value.
- No rounding beyond truncation, because the ALU supplies no guard bits. NaN inputs are out of scope.

## Timing
- Reset (asynchronous assert, registers take effect immediately): state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, overflow=0, and mant_r/exp_r/sign_r=0.
- Latency: out_valid rises k+1 cycles after the accepting edge, where k = number of left shifts (0..23). Carry, zero and overflow cases have k=0, so latency is 1 cycle. Worst case is 24 cycles.
- No overlap: in_ready=0 from the accepting edge until the cycle after the out_valid&out_ready handshake. Maximum throughput is one result per k+3 cycles.
- out_valid is held with result constant under backpressure for any number of cycles.
- in_valid asserted outside IDLE is ignored; the upstream stage must hold its data.
- rst mid-NORM or mid-DONE aborts the operation with no output produced. The block returns to reset values.

## Structure
- The shared fp package holds:
  - state enum (IDLE/NORM/DONE);
  - EXP_BIAS=127;
  - EXP_INF=8'hFF and EXP_MAX_NORMAL=8'hFE;
  - the packed result field offsets (sign 31, exponent 30:23, fraction 22:0).
- Single module, with no sub-module: the shifter is one bit per cycle and is inline.

## Test plan
- mant_in=25'h100_0000, exp_in=127, sign 0 (1.0+1.0) -> result=32'h4000_0000, zero=0, overflow=0, out_valid 1 cycle after accept.
- mant_in=25'h040_0000, exp_in=127, sign 1 -> one shift, result=32'hBF00_0000, out_valid 2 cycles after accept.
- mant_in=0, exp_in=100, sign 1 -> result=32'h0000_0000, zero=1, latency 1.
- mant_in=25'h100_0000, exp_in=254, sign 1 -> result=32'hFF80_0000, overflow=1.
- mant_in=25'h000_0001, exp_in=3 -> two shifts to exp 1, denormal result=32'h0000_0004, out_valid 3 cycles after accept.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles: result stable, in_ready=0.
  - Assert rst during NORM of a 20-shift case: out_valid never rises, in_ready=1 immediately.
  - A following transaction completes correctly.
